// File: rtl/weight_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// weight_load_sequencer_pkg
//
// Shared definitions for the weight load sequencer:
//   - state_t        : sequencer state encoding (IDLE, LOAD, READY, SWEEP)
//   - DEFAULT_WIDTH  : default weight word width in bits
//   - DEFAULT_LENGTH : default number of weight words held in the store
// -----------------------------------------------------------------------------
package weight_load_sequencer_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_LENGTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    SWEEP = 2'd3
  } state_t;

endpackage : weight_load_sequencer_pkg

// File: rtl/weight_load_sequencer_store.sv
// -----------------------------------------------------------------------------
// memory_serial_store
//
// Serial-load weight memory. Each enabled cycle pushes 'stream' into address 0
// and moves every older word up by one address; the word at the top address
// falls off. Read-out is combinational from 'addr'.
//
// Ports:
//   clk     in   1          rising-edge clock
//   reset   in   1          synchronous active-high reset, clears every word
//   enable  in   1          shift 'stream' into the store this cycle
//   stream  in   width      word to shift in
//   addr    in   addr_size  read address
//   out     out  width      word at 'addr' (0 for addresses past the end)
// -----------------------------------------------------------------------------
module memory_serial_store #(
  parameter int width     = 32,
  parameter int length    = 10,
  parameter int addr_size = $clog2(length)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [width-1:0]     stream,
  input  logic [addr_size-1:0] addr,
  output logic [width-1:0]     out
);

  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(length - 1);

  logic [width-1:0] r_mem [length];

  // NOTE: the array is cleared on reset because a stale load must never be
  // readable after reset; this keeps it in flops rather than a RAM macro,
  // which is fine for a store this small.
  // NOTE: every sequential assignment uses <=, so each word shifts from the
  // value its neighbour held before the edge, not the freshly written one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < length; i++) begin
        r_mem[i] <= '0;
      end
    end else if (enable) begin
      r_mem[0] <= stream;
      for (int i = 1; i < length; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Addresses beyond the last word read as zero instead of indexing past
  // the array when length is not a power of two.
  assign out = (addr <= LAST_ADDR) ? r_mem[addr] : '0;

endmodule : memory_serial_store

// File: rtl/weight_load_sequencer.sv
// -----------------------------------------------------------------------------
// weight_load_sequencer
//
// Loads 'length' weight words from a valid/ready stream into a serial-load
// store, then on request sweeps the whole store back out in arrival order
// over a valid/ready output port. The store is untouched by a sweep, so it
// may be swept any number of times until the next load or reset.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   start      in   1      begin a full load (honoured in IDLE and READY)
//   s_data     in   width  incoming load word
//   s_valid    in   1      s_data valid
//   s_ready    out  1      load word accepted (high throughout LOAD)
//   sweep_req  in   1      read back the whole store (honoured in READY)
//   out_data   out  width  read-back word, 0 when out_valid is low
//   out_valid  out  1      out_data valid (high throughout SWEEP)
//   out_ready  in   1      consumer accepts out_data
//   out_last   out  1      final word of a sweep
//   loaded     out  1      store holds a complete load (READY and SWEEP)
//   busy       out  1      sequencer in LOAD or SWEEP
// -----------------------------------------------------------------------------
module weight_load_sequencer
  import weight_load_sequencer_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int length    = DEFAULT_LENGTH,
  parameter int addr_size = $clog2(length)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             sweep_req,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             loaded,
  output logic             busy
);

  // Address of the oldest word, i.e. where a sweep begins.
  localparam logic [addr_size-1:0] LAST_ADDR = addr_size'(length - 1);

  state_t               r_state;
  logic [addr_size-1:0] r_count;
  logic [addr_size-1:0] r_rd_addr;

  state_t               w_next_state;
  logic [addr_size-1:0] w_next_count;
  logic [addr_size-1:0] w_next_rd_addr;
  logic                 w_load_hs;
  logic                 w_out_hs;
  logic [width-1:0]     w_store_out;

  // Handshakes derive from state so they cannot fire outside their phase.
  assign w_load_hs = s_valid && s_ready;
  assign w_out_hs  = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_rd_addr <= '0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_rd_addr <= w_next_rd_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a hold value before the case statement, so no
  // branch can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_next_count   = r_count;
    w_next_rd_addr = r_rd_addr;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = LOAD;
          w_next_count = '0;
        end
      end

      LOAD: begin
        if (w_load_hs) begin
          w_next_count = r_count + 1'b1;
          // The word accepted at count length-1 completes the load; s_ready
          // drops with the state change so no extra word is taken.
          if (r_count == LAST_ADDR) begin
            w_next_state = READY;
          end
        end
      end

      READY: begin
        // start outranks sweep_req when both arrive together.
        if (start) begin
          w_next_state = LOAD;
          w_next_count = '0;
        end else if (sweep_req) begin
          w_next_state   = SWEEP;
          w_next_rd_addr = LAST_ADDR;
        end
      end

      SWEEP: begin
        if (w_out_hs) begin
          // Address 0 is the newest word and ends the sweep; the address
          // stays at 0 rather than wrapping.
          if (r_rd_addr == '0) begin
            w_next_state = READY;
          end else begin
            w_next_rd_addr = r_rd_addr - 1'b1;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: purely state-derived, so they are glitch-free relative to inputs
  // and read as zero in IDLE (including throughout and after reset).
  // ---------------------------------------------------------------------------
  assign s_ready   = (r_state == LOAD);
  assign out_valid = (r_state == SWEEP);
  assign out_last  = (r_state == SWEEP) && (r_rd_addr == '0);
  assign out_data  = out_valid ? w_store_out : '0;
  assign loaded    = (r_state == READY) || (r_state == SWEEP);
  assign busy      = (r_state == LOAD) || (r_state == SWEEP);

  // ---------------------------------------------------------------------------
  // Weight store
  // ---------------------------------------------------------------------------
  memory_serial_store #(
    .width     (width),
    .length    (length),
    .addr_size (addr_size)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .enable (w_load_hs),
    .stream (s_data),
    .addr   (r_rd_addr),
    .out    (w_store_out)
  );

endmodule : weight_load_sequencer

// File: tb/tb_weight_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_weight_load_sequencer
//
// Directed bench for weight_load_sequencer (width=32, length=10). Inputs are
// driven and outputs sampled on the falling edge; the DUT's outputs depend
// only on registered state, so each sample reflects the last rising edge.
// -----------------------------------------------------------------------------
module tb_weight_load_sequencer;

  localparam int W   = 32;
  localparam int LEN = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic         sweep_req;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         loaded;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  weight_load_sequencer #(
    .width  (W),
    .length (LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .sweep_req (sweep_req),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .loaded    (loaded),
    .busy      (busy)
  );

  // One cycle of table stimulus: inputs for the coming rising edge plus the
  // outputs expected at the falling edge before it.
  typedef struct {
    logic         rst;
    logic         st;
    logic         sv;
    logic [W-1:0] sd;
    logic         sw;
    logic         ordy;
    logic         e_sr;
    logic         e_ov;
    logic         e_ol;
    logic [W-1:0] e_od;
    logic         e_ld;
    logic         e_bz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic st, logic sv, logic [W-1:0] sd,
                              logic sw, logic ordy, logic e_sr, logic e_ov,
                              logic e_ol, logic [W-1:0] e_od, logic e_ld,
                              logic e_bz);
    vec_t v;
    v.rst = rst; v.st = st; v.sv = sv; v.sd = sd; v.sw = sw; v.ordy = ordy;
    v.e_sr = e_sr; v.e_ov = e_ov; v.e_ol = e_ol; v.e_od = e_od;
    v.e_ld = e_ld; v.e_bz = e_bz;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic e_sr,
                               input logic e_ov, input logic e_ol,
                               input logic [W-1:0] e_od, input logic e_ld,
                               input logic e_bz);
    check({tag, ".s_ready"},   W'(s_ready),   W'(e_sr));
    check({tag, ".out_valid"}, W'(out_valid), W'(e_ov));
    check({tag, ".out_last"},  W'(out_last),  W'(e_ol));
    check({tag, ".out_data"},  out_data,      e_od);
    check({tag, ".loaded"},    W'(loaded),    W'(e_ld));
    check({tag, ".busy"},      W'(busy),      W'(e_bz));
  endtask

  // Starts a load from IDLE or READY and feeds LEN words base..base+LEN-1.
  // With 'toggle' set, every other cycle carries s_valid=0 and junk data.
  task automatic load_words(input string tag, input logic [W-1:0] base,
                            input bit toggle);
    int accepted = 0;
    int cyc      = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (accepted < LEN && cyc < 4 * LEN) begin
      if (toggle && (cyc % 2 == 1)) begin
        s_valid = 1'b0;
        s_data  = 32'hBAD0_0000 | W'(cyc);
      end else begin
        s_valid = 1'b1;
        s_data  = base + W'(accepted);
      end
      check_outputs($sformatf("%s.load%0d", tag, cyc), 1'b1, 1'b0, 1'b0, '0,
                    1'b0, 1'b1);
      @(negedge clk);
      if (s_valid) accepted++;
      cyc++;
    end
    s_valid = 1'b0;
    s_data  = '0;
    check_outputs({tag, ".loaded"}, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Sweeps from READY and expects base..base+LEN-1 in order. Word stall_idx
  // is held with out_ready=0 for stall_len cycles (stall_idx<0: no stall).
  task automatic sweep_check(input string tag, input logic [W-1:0] base,
                             input int stall_idx, input int stall_len);
    sweep_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (i == stall_idx) begin
        for (int s = 0; s < stall_len; s++) begin
          out_ready = 1'b0;
          check_outputs($sformatf("%s.stall%0d", tag, s), 1'b0, 1'b1,
                        (i == LEN - 1), base + W'(i), 1'b1, 1'b1);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      check_outputs($sformatf("%s.word%0d", tag, i), 1'b0, 1'b1,
                    (i == LEN - 1), base + W'(i), 1'b1, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check_outputs({tag, ".done"}, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    s_data    = '0;
    s_valid   = 1'b0;
    sweep_req = 1'b0;
    out_ready = 1'b0;

    // Table: reset state, load with s_valid held, ignored extra word,
    // full sweep with start ignored mid-sweep, start+sweep_req in READY,
    // reset out of LOAD.
    vecs.push_back(mk(0, 0, 0, '0, 1, 0,  0, 0, 0, '0, 0, 0)); // IDLE, sweep ignored
    vecs.push_back(mk(0, 1, 0, '0, 0, 0,  0, 0, 0, '0, 0, 0)); // IDLE, start
    for (int k = 0; k < LEN; k++)
      vecs.push_back(mk(0, 0, 1, 32'h100 + W'(k), 0, 0,  1, 0, 0, '0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 1, 1,  0, 0, 0, '0, 1, 0)); // READY
    for (int k = 0; k < LEN; k++)
      vecs.push_back(mk(0, (k == 2), 0, '0, 0, 1,
                        0, 1, (k == LEN - 1), 32'h100 + W'(k), 1, 1));
    vecs.push_back(mk(0, 1, 0, '0, 1, 0,  0, 0, 0, '0, 1, 0)); // READY, both
    vecs.push_back(mk(1, 0, 0, '0, 0, 0,  1, 0, 0, '0, 0, 1)); // LOAD, reset
    vecs.push_back(mk(0, 0, 0, '0, 0, 0,  0, 0, 0, '0, 0, 0)); // IDLE again

    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      check_outputs($sformatf("vec%0d", i), vecs[i].e_sr, vecs[i].e_ov,
                    vecs[i].e_ol, vecs[i].e_od, vecs[i].e_ld, vecs[i].e_bz);
      reset     = vecs[i].rst;
      start     = vecs[i].st;
      s_valid   = vecs[i].sv;
      s_data    = vecs[i].sd;
      sweep_req = vecs[i].sw;
      out_ready = vecs[i].ordy;
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    sweep_req = 1'b0; out_ready = 1'b0;

    // Load with s_valid toggling, then an unstalled sweep.
    load_words("toggle", 32'h100, 1'b1);
    sweep_check("sweep", 32'h100, -1, 0);

    // Sweep the same store again with a 3-cycle stall on the 4th word.
    sweep_check("stall", 32'h100, 3, 3);

    // Reset after 5 words of a load (a 6th handshake in the reset cycle).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 32'h100 + W'(k);
      @(negedge clk);
    end
    s_data = 32'h105;
    reset  = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    check_outputs("rst_load", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    load_words("reload", 32'h200, 1'b0);
    sweep_check("resweep", 32'h200, -1, 0);

    // Reset in the middle of a sweep.
    sweep_req = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    check_outputs("midsweep0", 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1);
    @(negedge clk);
    check_outputs("midsweep1", 1'b0, 1'b1, 1'b0, 32'h201, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    check_outputs("rst_sweep", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    // sweep_req in IDLE after reset must be ignored.
    sweep_req = 1'b1;
    @(negedge clk);
    sweep_req = 1'b0;
    check_outputs("idle_sweep", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_weight_load_sequencer
